// File: rtl/wrapper_vr_pkg.sv
// Shared types and helpers for the wrapper valid-ready packet arbiter.
// Holds the arbiter state encoding and the round-robin winner selection.
package wrapper_vr_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned RR_MAX_REQ     = 8;

  // Highest offset is visited first, so the lowest eligible offset from ptr
  // is the one left in win when the loop ends.
  function automatic logic [2:0] rr_select(
    input logic [RR_MAX_REQ-1:0] eligible,
    input logic [2:0]            ptr,
    input int unsigned           num_req
  );
    logic [2:0]  win;
    logic [2:0]  idx3;
    int unsigned off;
    int unsigned idx;
    win = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      off = RR_MAX_REQ - 1 - k;
      if (off < num_req) begin
        idx  = (32'(ptr) + off) % num_req;
        idx3 = 3'(idx);
        if (eligible[idx3]) begin
          win = idx3;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wrapper_vr_out_reg.sv
// Valid-ready pipeline register for beat data, last flag and source ID.
// Holds its contents while valid and not ready; o_free says a load may happen.
module wrapper_vr_out_reg #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic                  o_free
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
      r_id    <= i_id;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_id    = r_id;
  assign o_free  = ~r_valid | i_ready;

endmodule

// File: rtl/wrapper_vr_packet_arbiter.sv
// Round-robin, packet-atomic valid-ready arbiter feeding one engine input.
// A grant is held from the first beat through the beat carrying last.
module wrapper_vr_packet_arbiter
  import wrapper_vr_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          arb_enable,
  input  logic [NUM_REQ-1:0]            req_mask,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_out_last,
  output logic [ID_WIDTH-1:0]           data_out_id,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_count
);

  arb_state_e            r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_grant_id;
  logic [CNT_WIDTH-1:0]  r_pkt_count;

  logic [NUM_REQ-1:0]    w_eligible;
  logic [ID_WIDTH-1:0]   w_winner;
  logic                  w_out_free;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic                  w_xfer;
  logic                  w_out_done;

  assign w_eligible = arb_enable ? (req_valid & ~req_mask) : '0;
  assign w_winner   = ID_WIDTH'(rr_select(RR_MAX_REQ'(w_eligible), 3'(r_rr_ptr), NUM_REQ));

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_WIDTH'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_req_ready[i] = (r_state == ST_LOCKED) & w_out_free;
      end
    end
  end

  assign w_xfer     = (r_state == ST_LOCKED) & w_sel_valid & w_out_free;
  assign w_out_done = data_out_valid & data_out_ready & data_out_last;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_eligible) begin
            r_grant_id <= w_winner;
            r_state    <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_sel_last) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= (r_grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                : r_grant_id + ID_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_pkt_count <= '0;
    end else if (w_out_done) begin
      r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
    end
  end

  wrapper_vr_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_out_reg (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_load  (w_xfer),
    .i_data  (w_sel_data),
    .i_last  (w_sel_last),
    .i_id    (r_grant_id),
    .i_ready (data_out_ready),
    .o_valid (data_out_valid),
    .o_data  (data_out),
    .o_last  (data_out_last),
    .o_id    (data_out_id),
    .o_free  (w_out_free)
  );

  assign req_ready = w_req_ready;
  assign busy      = (r_state == ST_LOCKED);
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_wrapper_vr_packet_arbiter.sv
// Self-checking bench for wrapper_vr_packet_arbiter: directed scenarios plus
// a randomized phase scored against a packet-level round-robin model.
module tb_wrapper_vr_packet_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 16;

  logic             HCLK = 1'b0;
  logic             HRESET;
  logic             arb_enable;
  logic [NR-1:0]    req_mask;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    data_out;
  logic             data_out_last;
  logic [IW-1:0]    data_out_id;
  logic             data_out_valid;
  logic             data_out_ready;
  logic             busy;
  logic [CW-1:0]    pkt_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 HCLK = ~HCLK;

  wrapper_vr_packet_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .arb_enable     (arb_enable),
    .req_mask       (req_mask),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_id    (data_out_id),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clear_inputs();
    arb_enable     = 1'b1;
    req_mask       = '0;
    req_data       = '0;
    req_last       = '0;
    req_valid      = '0;
    data_out_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic set_beat(input int unsigned i, input logic [DW-1:0] d, input logic l);
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  // Randomized-phase model state: per-requester packet generator and the
  // expected beat stream ({last, data}) each requester will deliver.
  int unsigned   plen [NR];
  int unsigned   pidx [NR];
  logic [DW-1:0] pbeat [NR][4];
  logic [DW:0]   exp_q [NR][$];
  logic [NR-1:0] rmask;
  logic [NR-1:0] in_hs;
  int unsigned   exp_ptr;
  int unsigned   exp_id;
  int unsigned   pkts;
  bit            in_pkt;
  bit            found;
  bit            stall_prev;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_id;
  logic          prev_last;
  logic [DW:0]   e;

  task automatic new_packet(input int unsigned i);
    plen[i] = $urandom_range(4, 1);
    pidx[i] = 0;
    for (int unsigned b = 0; b < plen[i]; b++) begin
      pbeat[i][b] = {$urandom, $urandom};
      exp_q[i].push_back({(b == plen[i] - 1), pbeat[i][b]});
    end
  endtask

  initial begin
    // Reset values while reset is held
    clear_inputs();
    HRESET = 1'b1;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_valid", data_out_valid, 0);
    check_eq("rst_data", data_out, 0);
    check_eq("rst_id", data_out_id, 0);
    check_eq("rst_last", data_out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pkt_count", pkt_count, 0);
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Single requester, 3-beat packet
    req_valid = 4'b0001;
    set_beat(0, 64'h11, 1'b0);
    tick();
    check_eq("t1_busy", busy, 1);
    check_eq("t1_arb_no_out", data_out_valid, 0);
    check_eq("t1_ready", req_ready, 4'b0001);
    tick();
    check_eq("t1_b0_data", data_out, 64'h11);
    check_eq("t1_b0_valid", data_out_valid, 1);
    check_eq("t1_b0_id", data_out_id, 0);
    check_eq("t1_b0_last", data_out_last, 0);
    set_beat(0, 64'h22, 1'b0);
    tick();
    check_eq("t1_b1_data", data_out, 64'h22);
    check_eq("t1_b1_last", data_out_last, 0);
    set_beat(0, 64'h33, 1'b1);
    tick();
    check_eq("t1_b2_data", data_out, 64'h33);
    check_eq("t1_b2_last", data_out_last, 1);
    check_eq("t1_busy_end", busy, 0);
    req_valid = '0;
    tick();
    check_eq("t1_valid_clr", data_out_valid, 0);
    check_eq("t1_pkt_count", pkt_count, 1);

    // Reset mid-packet; rr pointer was advanced to 1 by the previous packet
    req_valid = 4'b0001;
    set_beat(0, 64'hD0, 1'b0);
    tick();
    tick();
    check_eq("rmp_beat", data_out, 64'hD0);
    HRESET = 1'b1;
    #1;
    check_eq("rmp_valid", data_out_valid, 0);
    check_eq("rmp_data", data_out, 0);
    check_eq("rmp_busy", busy, 0);
    check_eq("rmp_pkt_count", pkt_count, 0);
    check_eq("rmp_ready", req_ready, 0);
    req_valid = 4'b0101;
    set_beat(0, 64'hE0, 1'b1);
    set_beat(2, 64'hE2, 1'b1);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    tick();
    check_eq("rmp_restart_ready", req_ready, 4'b0001);
    tick();
    check_eq("rmp_restart_id", data_out_id, 0);
    check_eq("rmp_restart_data", data_out, 64'hE0);

    // Mask: only requester 3 eligible; unmasking 1 mid-packet does not interrupt
    do_reset();
    req_mask  = 4'b0010;
    req_valid = 4'b1010;
    set_beat(3, 64'hA0, 1'b0);
    set_beat(1, 64'hB1, 1'b1);
    tick();
    check_eq("mask_grant3", req_ready, 4'b1000);
    req_mask = 4'b0000;
    tick();
    check_eq("mask_b0_id", data_out_id, 3);
    check_eq("mask_b0_data", data_out, 64'hA0);
    set_beat(3, 64'hA1, 1'b1);
    tick();
    check_eq("mask_b1_id", data_out_id, 3);
    check_eq("mask_b1_last", data_out_last, 1);
    check_eq("mask_b1_busy", busy, 0);
    req_valid[3] = 1'b0;
    tick();
    check_eq("mask_next_grant1", req_ready, 4'b0010);
    tick();
    check_eq("mask_next_id", data_out_id, 1);
    check_eq("mask_next_data", data_out, 64'hB1);

    // arb_enable dropped mid-packet: packet completes, no new grant
    do_reset();
    req_valid = 4'b0001;
    set_beat(0, 64'hC0, 1'b0);
    tick();
    check_eq("en_busy", busy, 1);
    arb_enable = 1'b0;
    req_valid  = 4'b1111;
    tick();
    check_eq("en_b0_data", data_out, 64'hC0);
    set_beat(0, 64'hC1, 1'b1);
    tick();
    check_eq("en_b1_data", data_out, 64'hC1);
    check_eq("en_b1_last", data_out_last, 1);
    check_eq("en_b1_busy", busy, 0);
    req_valid = 4'b1110;
    tick();
    check_eq("en_off_busy0", busy, 0);
    tick();
    check_eq("en_off_busy1", busy, 0);
    check_eq("en_off_ready", req_ready, 0);
    arb_enable = 1'b1;
    tick();
    check_eq("en_on_grant1", req_ready, 4'b0010);

    // Randomized phase with a fixed mask and random output back-pressure
    do_reset();
    do begin
      rmask = NR'($urandom);
    end while (rmask == '1);
    req_mask = rmask;
    for (int unsigned i = 0; i < NR; i++) begin
      exp_q[i].delete();
      new_packet(i);
    end
    exp_ptr    = 0;
    exp_id     = 0;
    in_pkt     = 1'b0;
    pkts       = 0;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_id    = '0;
    prev_last  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int unsigned i = 0; i < NR; i++) begin
        req_valid[i] = (pidx[i] == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
        set_beat(i, pbeat[i][pidx[i]], (pidx[i] == plen[i] - 1));
      end
      data_out_ready = ($urandom_range(3, 0) != 0);
      #1;
      in_hs = req_valid & req_ready;
      check_eq("rnd_masked_ready", req_ready & rmask, 0);
      if (stall_prev) begin
        check_eq("rnd_stall_valid", data_out_valid, 1);
        check_eq("rnd_stall_data", data_out, prev_data);
        check_eq("rnd_stall_id", data_out_id, prev_id);
        check_eq("rnd_stall_last", data_out_last, prev_last);
      end
      if (data_out_valid && data_out_ready) begin
        if (!in_pkt) begin
          found = 1'b0;
          for (int unsigned k = 0; k < NR; k++) begin
            if (!found && !rmask[(exp_ptr + k) % NR]) begin
              exp_id = (exp_ptr + k) % NR;
              found  = 1'b1;
            end
          end
          in_pkt = 1'b1;
        end
        check_eq("rnd_out_id", data_out_id, exp_id);
        check_eq("rnd_exp_avail", exp_q[exp_id].size() != 0, 1);
        if (exp_q[exp_id].size() != 0) begin
          e = exp_q[exp_id].pop_front();
          check_eq("rnd_out_data", data_out, e[DW-1:0]);
          check_eq("rnd_out_last", data_out_last, e[DW]);
          if (e[DW]) begin
            in_pkt  = 1'b0;
            exp_ptr = (exp_id + 1) % NR;
            pkts++;
          end
        end
      end
      stall_prev = data_out_valid & ~data_out_ready;
      prev_data  = data_out;
      prev_id    = data_out_id;
      prev_last  = data_out_last;
      @(posedge HCLK);
      #1;
      for (int unsigned i = 0; i < NR; i++) begin
        if (in_hs[i]) begin
          if (pidx[i] == plen[i] - 1) new_packet(i);
          else pidx[i]++;
        end
      end
    end
    check_eq("rnd_pkt_count", pkt_count, CW'(pkts));
    check_eq("rnd_progress", pkts > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
